// File: rtl/floor_divmod_seq.sv
// Sequential signed floor division. The quotient is rounded toward minus
// infinity, and the remainder is zero or takes the sign of the divisor.
// Magnitudes are divided by a restoring shift-subtract loop, one bit per
// cycle. A single fix-up cycle then turns the truncated results into floor
// results. A zero divisor skips the loop and returns quot = 0, rem = a.
module floor_divmod_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] quot,
  output logic [WIDTH-1:0] rem,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_CNT = CW'(WIDTH - 1);
  localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
  localparam logic [WIDTH-1:0] ZERO_W   = {WIDTH{1'b0}};
  localparam logic [WIDTH-1:0] ONE_W    = WIDTH'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t state_r;
  state_t state_s;

  logic [CW-1:0]    cnt_r;     // iteration counter for the divide loop
  logic [WIDTH-1:0] q_r;       // dividend magnitude shifting out, quotient bits shifting in
  logic [WIDTH-1:0] d_r;       // divisor magnitude
  logic [WIDTH:0]   pr_r;      // partial remainder, one guard bit wide
  logic [WIDTH-1:0] b_r;       // original signed divisor, used by the floor correction
  logic             sign_a_r;  // sign of the dividend
  logic [WIDTH-1:0] quot_r;
  logic [WIDTH-1:0] rem_r;
  logic             div_zero_r;

  logic [WIDTH+1:0] shifted_s;
  logic [WIDTH+1:0] diff_s;
  logic             qbit_s;
  logic [WIDTH-1:0] qt_s;
  logic [WIDTH-1:0] rt_s;
  logic [WIDTH-1:0] fquot_s;
  logic [WIDTH-1:0] frem_s;

  // Two's-complement negation modulo 2^WIDTH.
  function automatic logic [WIDTH-1:0] negate(input logic [WIDTH-1:0] v);
    negate = ~v + ONE_W;
  endfunction

  // Unsigned magnitude. The most negative value maps to 2^(WIDTH-1).
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v);
    if (v[WIDTH-1]) begin
      magnitude = negate(v);
    end else begin
      magnitude = v;
    end
  endfunction

  assign in_ready  = (state_r == IDLE);
  assign out_valid = (state_r == DONE);
  assign quot      = quot_r;
  assign rem       = rem_r;
  assign div_zero  = div_zero_r;

  // Restoring step: shift the next dividend bit in and trial-subtract the divisor.
  always_comb begin
    shifted_s = {pr_r, q_r[WIDTH-1]};
    diff_s    = shifted_s - {2'b00, d_r};
    qbit_s    = ~diff_s[WIDTH+1];
  end

  // Floor correction of the truncated magnitude results.
  always_comb begin
    fquot_s = ZERO_W;
    frem_s  = ZERO_W;
    if (sign_a_r ^ b_r[WIDTH-1]) begin
      qt_s = negate(q_r);
    end else begin
      qt_s = q_r;
    end
    if (sign_a_r) begin
      rt_s = negate(pr_r[WIDTH-1:0]);
    end else begin
      rt_s = pr_r[WIDTH-1:0];
    end
    if ((rt_s != ZERO_W) && (sign_a_r != b_r[WIDTH-1])) begin
      fquot_s = qt_s - ONE_W;
      frem_s  = rt_s + b_r;
    end else begin
      fquot_s = qt_s;
      frem_s  = rt_s;
    end
  end

  // Next-state logic of the control FSM.
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          if (b == ZERO_W) begin
            state_s = DONE;
          end else begin
            state_s = CALC;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        if (cnt_r == LAST_CNT) begin
          state_s = FIX;
        end else begin
          state_s = CALC;
        end
      end
      FIX: begin
        state_s = DONE;
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Datapath: capture operands, run the divide loop, and register the results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= {CW{1'b0}};
      q_r        <= ZERO_W;
      d_r        <= ZERO_W;
      pr_r       <= {(WIDTH+1){1'b0}};
      b_r        <= ZERO_W;
      sign_a_r   <= 1'b0;
      quot_r     <= ZERO_W;
      rem_r      <= ZERO_W;
      div_zero_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            if (b == ZERO_W) begin
              quot_r     <= ZERO_W;
              rem_r      <= a;
              div_zero_r <= 1'b1;
            end else begin
              q_r        <= magnitude(a);
              d_r        <= magnitude(b);
              pr_r       <= {(WIDTH+1){1'b0}};
              cnt_r      <= {CW{1'b0}};
              sign_a_r   <= a[WIDTH-1];
              b_r        <= b;
              div_zero_r <= 1'b0;
            end
          end
        end
        CALC: begin
          if (qbit_s) begin
            pr_r <= diff_s[WIDTH:0];
          end else begin
            pr_r <= shifted_s[WIDTH:0];
          end
          q_r   <= {q_r[WIDTH-2:0], qbit_s};
          cnt_r <= cnt_r + CNT_ONE;
        end
        FIX: begin
          quot_r <= fquot_s;
          rem_r  <= frem_s;
        end
        DONE: begin
          quot_r <= quot_r;
        end
        default: begin
          quot_r <= quot_r;
        end
      endcase
    end
  end

endmodule

// File: doc/floor_divmod_seq.md
FLOOR_DIVMOD_SEQ -- requirements
Module: floor_divmod_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand and result width in bits, legal range 2..32.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-005 SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-006 SHALL have port a, input, WIDTH bits: signed dividend.
REQ-007 SHALL have port b, input, WIDTH bits: signed divisor.
REQ-008 SHALL have port out_valid, output, 1 bit: results are valid.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts the results.
REQ-010 SHALL have port quot, output, WIDTH bits: signed floor quotient.
REQ-011 SHALL have port rem, output, WIDTH bits: signed floor remainder.
REQ-012 SHALL have port div_zero, output, 1 bit: the divisor was zero.

Function
REQ-013 SHALL implement a state machine with states IDLE, CALC, FIX and DONE.
REQ-014 in_ready SHALL equal (state == IDLE), decoded combinationally from the state register.
REQ-015 Accept SHALL occur on a clk edge where in_valid && in_ready; call this edge 0.
  - On accept, a and b SHALL be captured.
  - Operands SHALL NOT be sampled at any other edge.
REQ-016 On accept with b != 0:
  - Load the unsigned magnitudes |a| and |b| (WIDTH bits; |-2^(WIDTH-1)| = 2^(WIDTH-1)) and the two sign bits.
  - Clear the iteration counter.
  - Enter CALC.
REQ-017 CALC SHALL perform one restoring shift-subtract step per cycle, for WIDTH cycles (edges 1..WIDTH).
  - The partial remainder register SHALL be WIDTH+1 bits.
  - After edge WIDTH, the state SHALL be FIX.
REQ-018 FIX (one cycle, edge WIDTH+1) SHALL convert the truncated magnitude results to floor results, then enter DONE:
  - qt = sign(a)^sign(b) ? -|q| : |q|.
  - rt = sign(a) ? -|r| : |r|.
  - If rt != 0 and sign(a) != sign(b): quot = qt - 1 and rem = rt + b.
  - Otherwise: quot = qt and rem = rt.
REQ-019 All arithmetic SHALL be modulo 2^WIDTH.
  - Example: a = -2^(WIDTH-1), b = -1 gives quot = -2^(WIDTH-1), rem = 0.
REQ-020 The results SHALL always satisfy a == b*quot + rem (mod 2^WIDTH).
  - rem SHALL be 0 or have the sign of b.
  - |rem| SHALL be less than |b|.
REQ-021 Non-zero-divisor latency: out_valid SHALL be 1 from the cycle following edge WIDTH+1.
REQ-022 On accept with b == 0, the block SHALL skip CALC and FIX and enter DONE at edge 0:
  - quot = 0, rem = a, div_zero = 1.
  - out_valid SHALL be 1 in the cycle after the accept.
REQ-023 div_zero SHALL be 0 for every non-zero divisor.
REQ-024 out_valid SHALL equal (state == DONE).
REQ-025 While in DONE with out_ready == 0, quot, rem and div_zero SHALL hold stable.
REQ-026 On an edge where out_valid && out_ready, the state SHALL become IDLE.
  - in_ready SHALL rise in the next cycle.
  - The block SHALL NOT accept operands on that same edge (no back-to-back overlap).
REQ-027 quot, rem and div_zero SHALL be registered outputs.
  - Their values outside DONE are don't-care, except as stated in REQ-029.
REQ-028 in_valid and the operands SHALL be ignored in CALC, FIX and DONE.

Reset
REQ-029 While rst_n == 0, the block SHALL immediately (asynchronously) force:
  - state = IDLE, in_ready = 1, out_valid = 0;
  - quot = 0, rem = 0, div_zero = 0;
  - the iteration counter to 0.
REQ-030 Reset asserted in any state, including mid-CALC, SHALL abort the operation with no result emitted.
  - The first accept after rst_n rises SHALL behave exactly as from power-up.
REQ-031 Deassertion of rst_n SHALL take effect at the first clk edge after release.
  - No accept SHALL occur on an edge where rst_n is low.

Verification (WIDTH = 8)
REQ-032 The bench SHALL cover these directed scenarios:
  - a=7, b=2 -> quot=3, rem=1, div_zero=0; out_valid first high 9 cycles after accept.
  - a=-7, b=2 -> quot=-4, rem=1.
  - a=7, b=-2 -> quot=-4, rem=-1.
  - a=-7, b=-2 -> quot=3, rem=-1.
  - a=-128, b=-1 -> quot=-128, rem=0.
  - a=5, b=0 -> quot=0, rem=5, div_zero=1; out_valid high in the cycle after accept.
  - out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; one cycle after out_ready=1 -> in_ready=1.
  - rst_n pulsed low at CALC iteration 4 -> out_valid stays 0; a subsequent a=9, b=4 -> quot=2, rem=1.
REQ-033 A formal property SHALL check REQ-020 for all a, and all b != 0, under $anyconst operands.
  - It SHALL also check that out_valid never rises except WIDTH+1 edges after an accept (b != 0) or 1 edge after an accept (b == 0).
